// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: parity modes, FSM states, frame sizing.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Serial bit times in one frame: start + data + optional parity + stop bits.
  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO; full/empty are decoded from a registered occupancy count.
// Latency: a pushed word is visible on pop_dat the cycle after the push edge.
// Backpressure: push is dropped while full (even with a same-cycle pop); pop is ignored when empty.
// Ports: clock_system, rst (sync, active-high), push/push_dat, pop/pop_dat (head word,
//        combinational read), full, empty, level (0..DEPTH).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clock_system,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == LVL_FULL);
  assign empty   = (count == '0);
  assign level   = count;
  assign pop_dat = mem[rd_ptr];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage carries no reset; validity is tracked entirely by the pointers and count.
  always_ff @(posedge clock_system) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clock_system) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push_ok && !pop_ok) begin
        count <= count + (AW+1)'(1);
      end else if (pop_ok && !push_ok) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with input FIFO: configurable data bits, parity and stop bits, gap-free frames.
// Latency: the start bit appears on tx the edge after the FIFO pop (one cycle after a push into an idle, empty FIFO).
// Backpressure: tx_ready = !full; tx_enable is sampled only at frame boundaries and never truncates a frame.
// Ports: clock_system, rst (sync, active-high), tx_data/tx_valid/tx_ready (byte push),
//        tx_enable (frame-start gate), tx (serial out, idle high), busy (frame in progress), fifo_level.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1250,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clock_system,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic                          tx_enable,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  uart_state_e          state_q;
  uart_state_e          state_d;
  logic [BW-1:0]        baud_q;
  logic [BW-1:0]        baud_d;
  logic [2:0]           bit_q;
  logic [2:0]           bit_d;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic                 par_q;
  logic                 par_d;
  logic                 tx_d;
  logic                 baud_end;
  logic                 start_ok;
  logic                 frame_load;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_dat;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock_system (clock_system),
    .rst          (rst),
    .push         (tx_valid),
    .push_dat     (tx_data),
    .pop          (fifo_pop),
    .pop_dat      (fifo_dat),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .level        (fifo_level)
  );

  assign tx_ready = !fifo_full;
  assign busy     = (state_q != ST_IDLE);
  assign baud_end = (baud_q == BAUD_LAST);
  assign start_ok = !fifo_empty && tx_enable;

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q + BW'(1);
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_d      = par_q;
    frame_load = 1'b0;
    fifo_pop   = 1'b0;
    tx_d       = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        baud_d     = '0;
        bit_d      = '0;
        frame_load = start_ok;
      end
      ST_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'(STOP_BITS - 1)) begin
            bit_d      = '0;
            state_d    = ST_IDLE;
            // Chaining straight into the next start bit keeps frames gap-free.
            frame_load = start_ok;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase

    if (frame_load) begin
      fifo_pop = 1'b1;
      shift_d  = fifo_dat;
      par_d    = (PARITY == PAR_ODD) ? ~^fifo_dat : ^fifo_dat;
      baud_d   = '0;
      bit_d    = '0;
      state_d  = ST_START;
    end

    // tx is registered from the next-state view so the line changes on the state-entry edge.
    unique case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock_system) begin
    if (rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx      <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx      <= tx_d;
    end
  end

endmodule
